// File: rtl/serialize_num_pkg.sv
// Shared types and constants for the serializer and its neighbouring
// length-measuring stage.
package serialize_num_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Effective bit count: a requested length never exceeds the datapath width.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    return (len > width) ? width : len;
  endfunction

endpackage

// File: rtl/serialize_num_if.sv
// Bus bundle for serialize_num: start/capture inputs, serial output stream
// and status.
//
// Handshake: a bit transfers on a rising clk edge where bit_valid and
// bit_ready are both 1. While bit_valid=1 and bit_ready=0, bit_out and
// bits_left hold unchanged for as long as the stall lasts; bit_valid never
// drops without a transfer. bit_ready may change freely and has no effect
// while bit_valid=0.
interface serialize_num_if #(
  parameter int WIDTH = 64,
  parameter int LEN_W = 8
);
  logic             md_start;
  logic [WIDTH-1:0] num_in;
  logic [LEN_W-1:0] len_in;
  logic             bit_ready;
  logic             bit_out;
  logic             bit_valid;
  logic [LEN_W-1:0] bits_left;
  logic             busy;
  logic             md_end;

  modport master (
    output md_start, num_in, len_in, bit_ready,
    input  bit_out, bit_valid, bits_left, busy, md_end
  );

  modport slave (
    input  md_start, num_in, len_in, bit_ready,
    output bit_out, bit_valid, bits_left, busy, md_end
  );
endinterface

// File: rtl/serialize_num_shreg.sv
// Left-aligned load/shift register; the MSB is the bit currently on offer.
module serial_shreg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  // Load takes priority; each shift exposes the next lower bit at the MSB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_val;
    end else if (shift_en) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serialize_num.sv
// Bit-serial transmitter: captures a number and its length, then emits the
// low L bits MSB-first under a valid/ready handshake, ending with md_end.
module serialize_num
  import serialize_num_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  serialize_num_if.slave  bus,
  output state_e          dbg_state
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  int               shamt;
  logic             load;
  logic             shift_en;
  logic             msb;

  // Left-align so num_in[L-1] lands on the MSB; bits above L-1 fall off the
  // top. L=0 gives a shift of WIDTH, which loads zero.
  assign eff_len = LEN_W'(clamp_len(32'(bus.len_in), WIDTH));
  assign shamt   = WIDTH - int'(eff_len);
  assign aligned = bus.num_in << shamt;

  serial_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .load_val (aligned),
    .shift_en (shift_en),
    .msb      (msb)
  );

  // State and remaining-bit counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
    end
  end

  // Next-state logic: capture in IDLE, one bit per transfer in SHIFT,
  // single-cycle DONE. Starts outside IDLE are dropped.
  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.md_start) begin
          load = 1'b1;
          if (eff_len == '0) begin
            state_d = ST_DONE;
            left_d  = '0;
          end else begin
            state_d = ST_SHIFT;
            left_d  = eff_len;
          end
        end
      end
      ST_SHIFT: begin
        if (bus.bit_ready) begin
          shift_en = 1'b1;
          if (left_q == LEN_W'(1)) begin
            state_d = ST_DONE;
            left_d  = '0;
          end else begin
            left_d  = left_q - LEN_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        left_d  = '0;
      end
    endcase
  end

  // Outputs decode flops only, so nothing from an input reaches an output
  // combinationally and reset clears every output at once.
  assign bus.bit_out   = msb;
  assign bus.bit_valid = (state_q == ST_SHIFT);
  assign bus.bits_left = left_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.md_end    = (state_q == ST_DONE);
  assign dbg_state     = state_q;

endmodule
